// File: rtl/mod_inv_bin_pkg.sv
// Shared constants for the Curve25519 field inverter: field width, prime q,
// controller state encoding and the modular halving helper.
package mod_inv_bin_pkg;

  localparam int W = 255;

  // q = 2^255 - 19
  localparam logic [W-1:0] q =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // x/2 mod q for x in [0, q): odd values borrow q first, sum fits in W+1 bits.
  function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return s[W:1];
  endfunction

endpackage

// File: rtl/mod_inv_bin_add_sub.sv
// Combinational modular adder/subtractor over q; operands must lie in [0, q).
module mod_inv_bin_add_sub
  import mod_inv_bin_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         add_i,
  output logic [W-1:0] res_o
);

  logic [W:0] sum;
  logic [W:0] sum_red;
  logic [W:0] diff;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    sum_red = sum - {1'b0, q};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    // The top bit of each W+1-bit result is the borrow of that subtraction.
    if (add_i) begin
      res_o = sum_red[W] ? sum[W-1:0] : sum_red[W-1:0];
    end else begin
      res_o = diff[W] ? (diff[W-1:0] + q) : diff[W-1:0];
    end
  end

endmodule

// File: rtl/mod_inv_bin.sv
// Field inverter a^-1 mod q using the binary extended Euclidean algorithm,
// one reduction step per clock. in: valid/ready; out: single-cycle valid pulse.
module mod_inv_bin
  import mod_inv_bin_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  input  logic [254:0] i_a,
  output logic         o_in_ready,
  output logic         o_out_valid,
  output logic [254:0] o_result,
  output logic         o_zero,
  output logic         o_busy
);

  // Handshake: an operand transfers on a rising edge where i_in_valid and
  // o_in_ready are both high; o_out_valid is a one-cycle pulse with no backpressure.

  state_e       state_q, state_d;
  logic [W-1:0] u_q, u_d, v_q, v_d;
  logic [W-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [W-1:0] result_q, result_d;
  logic         zero_q, zero_d;
  logic [10:0]  step_q, step_d;

  logic         u_ge_v;
  logic [W-1:0] as_a, as_b, as_res;

  // One shared subtractor: x1 - x2 when u >= v, else x2 - x1.
  assign u_ge_v = (u_q >= v_q);
  assign as_a   = u_ge_v ? x1_q : x2_q;
  assign as_b   = u_ge_v ? x2_q : x1_q;

  mod_inv_bin_add_sub u_add_sub (
    .a_i   (as_a),
    .b_i   (as_b),
    .add_i (1'b0),
    .res_o (as_res)
  );

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    result_d = result_q;
    zero_d   = zero_q;
    step_d   = step_q;
    case (state_q)
      IDLE: begin
        if (i_in_valid) begin
          step_d = 11'd0;
          if (i_a == '0) begin
            state_d  = DONE;
            zero_d   = 1'b1;
            result_d = '0;
          end else begin
            state_d = ITER;
            zero_d  = 1'b0;
            u_d     = i_a;
            v_d     = q;
            x1_d    = {{(W-1){1'b0}}, 1'b1};
            x2_d    = '0;
          end
        end
      end
      ITER: begin
        if (step_q != 11'h7ff) step_d = step_q + 11'd1;
        if (u_q == {{(W-1){1'b0}}, 1'b1}) begin
          result_d = x1_q;
          state_d  = DONE;
        end else if (v_q == {{(W-1){1'b0}}, 1'b1}) begin
          result_d = x2_q;
          state_d  = DONE;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = half_mod(x1_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = half_mod(x2_q);
        end else if (u_ge_v) begin
          u_d  = u_q - v_q;
          x1_d = as_res;
        end else begin
          v_d  = v_q - u_q;
          x2_d = as_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      step_q   <= 11'd0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      step_q   <= step_d;
    end
  end

  assign o_in_ready  = (state_q == IDLE);
  assign o_out_valid = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);
  assign o_result    = result_q;
  assign o_zero      = zero_q;

endmodule

// File: tb/tb_mod_inv_bin.sv
// Self-checking bench for mod_inv_bin: directed corner operands, random operands
// checked by a modular-product reference, input-hold and mid-run reset scenarios.
module tb_mod_inv_bin;

  localparam logic [254:0] QREF =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [254:0] HALF_INV2 =
    255'h3fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffff7;
  localparam int N_RAND = 40;
  localparam int LAT_LIMIT = 1100;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [254:0] a_in;
  logic         in_ready;
  logic         out_valid;
  logic [254:0] result;
  logic         zero;
  logic         busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [254:0] exp_q[$];

  mod_inv_bin dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_a         (a_in),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_result    (result),
    .o_zero      (zero),
    .o_busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
    logic [511:0] p;
    logic [511:0] r;
    p = {257'd0, x} * {257'd0, y};
    r = p % {257'd0, QREF};
    return r[254:0];
  endfunction

  function automatic logic [254:0] rand_a();
    logic [255:0] t;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    r = t % {1'b0, QREF};
    if (r == '0) r = 256'd1;
    return r[254:0];
  endfunction

  // ---------------- driver ----------------
  // Present one operand from IDLE and collect the result pulse.
  task automatic run_op(input logic [254:0] a, output logic [254:0] res,
                        output logic z, output int lat, output int steps);
    @(negedge clk);
    chk("ready_before_accept", 256'(in_ready), 256'd1);
    in_valid = 1'b1;
    a_in     = a;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = rand_a();
    lat = 1;
    while (!out_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    res   = result;
    z     = zero;
    steps = int'(dut.step_q);
    chk("out_valid_seen", 256'(out_valid), 256'd1);
    @(negedge clk);
    chk("out_valid_one_cycle", 256'(out_valid), 256'd0);
    chk("result_holds", 256'(result), 256'(res));
    chk("ready_after_done", 256'(in_ready), 256'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [254:0] res, a1, a2, exp_v;
    logic         z;
    int           lat, steps, k;

    rst      = 1'b1;
    in_valid = 1'b0;
    a_in     = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 256'(in_ready), 256'd1);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_result", 256'(result), 256'd0);
    chk("rst_zero", 256'(zero), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    rst = 1'b0;

    // Directed corners: a = 1, 2, q-1 have known inverses.
    exp_q.push_back(255'd1);
    exp_q.push_back(HALF_INV2);
    exp_q.push_back(QREF - 255'd1);

    run_op(255'd1, res, z, lat, steps);
    exp_v = exp_q.pop_front();
    chk("a1_result", 256'(res), 256'(exp_v));
    chk("a1_zero", 256'(z), 256'd0);
    chk("a1_latency", 256'(lat), 256'd2);

    run_op(255'd2, res, z, lat, steps);
    exp_v = exp_q.pop_front();
    chk("a2_result", 256'(res), 256'(exp_v));
    chk("a2_latency", 256'(lat), 256'd3);

    run_op(QREF - 255'd1, res, z, lat, steps);
    exp_v = exp_q.pop_front();
    chk("aqm1_result", 256'(res), 256'(exp_v));
    chk("aqm1_latency_bound", 256'(lat <= 1022), 256'd1);

    run_op(255'd0, res, z, lat, steps);
    chk("a0_result", 256'(res), 256'd0);
    chk("a0_zero", 256'(z), 256'd1);
    chk("a0_latency", 256'(lat), 256'd1);

    // Random operands against the modular-product reference.
    for (int i = 0; i < N_RAND; i++) begin
      a1 = rand_a();
      run_op(a1, res, z, lat, steps);
      chk("rand_inverse", 256'(mulmod(res, a1)), 256'd1);
      chk("rand_result_range", 256'(res < QREF), 256'd1);
      chk("rand_zero", 256'(z), 256'd0);
      chk("rand_latency_bound", 256'(lat <= 1022), 256'd1);
      chk("rand_step_bound", 256'(steps <= 1020), 256'd1);
      chk("rand_step_vs_latency", 256'(steps), 256'(lat - 1));
    end

    // i_in_valid held through ITER with a different operand.
    a1 = rand_a();
    a2 = rand_a();
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = a1;
    @(posedge clk);
    @(negedge clk);
    chk("hold_busy", 256'(busy), 256'd1);
    a_in = a2;
    k = 1;
    while (!out_valid && k < LAT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk("hold_done_seen", 256'(out_valid), 256'd1);
    chk("hold_first_operand", 256'(mulmod(result, a1)), 256'd1);
    @(negedge clk);
    chk("hold_ready_after_done", 256'(in_ready), 256'd1);
    @(negedge clk);
    chk("hold_reaccept", 256'(busy), 256'd1);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < LAT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk("hold_second_done_seen", 256'(out_valid), 256'd1);
    chk("hold_second_operand", 256'(mulmod(result, a2)), 256'd1);

    // Reset in the middle of an iteration.
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = rand_a();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_busy_before", 256'(busy), 256'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 256'(in_ready), 256'd1);
    chk("midrst_out_valid", 256'(out_valid), 256'd0);
    chk("midrst_result", 256'(result), 256'd0);
    chk("midrst_zero", 256'(zero), 256'd0);
    chk("midrst_busy", 256'(busy), 256'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 256'(out_valid), 256'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_no_valid", 256'(out_valid), 256'd0);
    end
    run_op(255'd2, res, z, lat, steps);
    chk("postrst_a2_result", 256'(res), 256'(HALF_INV2));
    chk("postrst_a2_latency", 256'(lat), 256'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
